// File: rtl/score_bcd_if.sv
// Score conversion request/result bundle between the score source and the
// BCD converter that feeds the seven-segment stage.
interface score_bcd_if;
  logic [15:0] bin_score;
  logic        load;
  logic        busy;
  logic [15:0] bcd_score;
  logic        bcd_valid;
  logic        overflow;

  modport master (
    output bin_score, load,
    input  busy, bcd_score, bcd_valid, overflow
  );

  modport slave (
    input  bin_score, load,
    output busy, bcd_score, bcd_valid, overflow
  );
endinterface

// File: rtl/score_bcd.sv
// Sequential double-dabble binary-to-BCD converter with saturation; one bit per
// clock, the displayed result changes only once a conversion has completed.
module score_bcd #(
  parameter logic [15:0] SAT_VALUE = 16'd9999
) (
  input logic        clk,
  input logic        rst_n,
  score_bcd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] bin_reg;
  logic [15:0] work_reg;
  logic [15:0] bcd_out_reg;
  logic [4:0]  cnt_reg;
  logic        valid_reg;
  logic        ovf_reg;
  logic [15:0] work_adj;
  logic [15:0] clamped;
  logic        over_sat;

  assign over_sat = (bus.bin_score > SAT_VALUE);
  assign clamped  = over_sat ? SAT_VALUE : bus.bin_score;

  // Add-3 correction on each nibble independently, no carry between digits.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign work_adj[gi*4 +: 4] = (work_reg[gi*4 +: 4] >= 4'd5) ?
                                   work_reg[gi*4 +: 4] + 4'd3 :
                                   work_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.load) state_next = CONV;
      CONV:    if (cnt_reg == 5'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_reg     <= '0;
      work_reg    <= '0;
      bcd_out_reg <= '0;
      cnt_reg     <= '0;
      valid_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.load) begin
            bin_reg  <= clamped;
            work_reg <= '0;
            cnt_reg  <= '0;
            ovf_reg  <= over_sat;
          end
        end
        CONV: begin
          {work_reg, bin_reg} <= {work_adj, bin_reg} << 1;
          cnt_reg             <= cnt_reg + 5'd1;
        end
        DONE: begin
          bcd_out_reg <= work_reg;
          valid_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.bcd_score = bcd_out_reg;
  assign bus.bcd_valid = valid_reg;
  assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_score_bcd.sv
// Self-checking bench for score_bcd: vector table, hand-written corner
// sequences, random loads and a strided back-to-back sweep against a decimal model.
module tb_score_bcd;

  localparam int SAT = 9999;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  score_bcd_if bus ();

  score_bcd #(.SAT_VALUE(16'd9999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [15:0] ref_bcd(input int v);
    int c;
    c = (v > SAT) ? SAT : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one load at the current cycle and wait for its result.
  task automatic run_conv(input logic [15:0] v, output logic [15:0] bcd,
                          output logic ovf, output int lat, output int busy_cnt);
    bus.bin_score = v;
    bus.load      = 1'b1;
    @(posedge clk); #1;
    bus.load      = 1'b0;
    bus.bin_score = 16'($urandom);
    lat      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.bcd_valid) begin
        lat = c;
        break;
      end
      if (bus.busy) busy_cnt++;
      bus.bin_score = 16'($urandom);
    end
    bcd = bus.bcd_score;
    ovf = bus.overflow;
  endtask

  initial begin
    logic [15:0] got;
    logic        ovf;
    int          lat, bcnt, nv, v;

    vecs[0]  = '{16'd0,     16'h0000, 1'b0};
    vecs[1]  = '{16'd1234,  16'h1234, 1'b0};
    vecs[2]  = '{16'd5,     16'h0005, 1'b0};
    vecs[3]  = '{16'd10,    16'h0010, 1'b0};
    vecs[4]  = '{16'd99,    16'h0099, 1'b0};
    vecs[5]  = '{16'd100,   16'h0100, 1'b0};
    vecs[6]  = '{16'd1000,  16'h1000, 1'b0};
    vecs[7]  = '{16'd9999,  16'h9999, 1'b0};
    vecs[8]  = '{16'd10000, 16'h9999, 1'b1};
    vecs[9]  = '{16'd8765,  16'h8765, 1'b0};
    vecs[10] = '{16'd65535, 16'h9999, 1'b1};

    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.bin_score = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset bcd_score", 32'(bus.bcd_score), 32'h0000);
    check("reset bcd_valid", 32'(bus.bcd_valid), 32'd0);
    check("reset overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_conv(vecs[i].bin, got, ovf, lat, bcnt);
      $display("table %0d: bin=%0d bcd=%h ovf=%0d lat=%0d", i, vecs[i].bin, got, ovf, lat);
      check("table latency", 32'(lat), 32'd17);
      check("table bcd", 32'(got), 32'(vecs[i].exp_bcd));
      check("table overflow", 32'(ovf), 32'(vecs[i].exp_ovf));
    end

    repeat (5) @(posedge clk);
    #1;
    check("overflow hold", 32'(bus.overflow), 32'd1);

    run_conv(16'd1234, got, ovf, lat, bcnt);
    $display("seq 1234: bcd=%h busy_cycles=%0d lat=%0d", got, bcnt, lat);
    check("1234 busy cycles", 32'(bcnt), 32'd17);
    check("1234 bcd", 32'(got), 32'h1234);
    check("1234 overflow", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    check("1234 valid single", 32'(bus.bcd_valid), 32'd0);

    // Second load mid-conversion must be dropped.
    bus.bin_score = 16'd42;
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      bus.bin_score = 16'($urandom);
    end
    bus.bin_score = 16'd77;
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    nv = 0; lat = 0; got = '0;
    for (int c = 6; c <= 45; c++) begin
      @(posedge clk); #1;
      bus.bin_score = 16'($urandom);
      if (bus.bcd_valid) begin
        nv++;
        if (lat == 0) begin
          lat = c;
          got = bus.bcd_score;
        end
      end
    end
    $display("seq 42/77: bcd=%h lat=%0d pulses=%0d", got, lat, nv);
    check("42 latency", 32'(lat), 32'd17);
    check("42 bcd", 32'(got), 32'h0042);
    check("42 pulse count", 32'(nv), 32'd1);

    // Load presented during the DONE cycle must be ignored.
    bus.bin_score = 16'd300;
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    bus.bin_score = 16'd555;
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    check("300 valid", 32'(bus.bcd_valid), 32'd1);
    check("300 bcd", 32'(bus.bcd_score), 32'h0300);
    @(posedge clk); #1;
    check("done load ignored busy", 32'(bus.busy), 32'd0);
    nv = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.bcd_valid) nv++;
    end
    $display("seq done-load: extra pulses=%0d", nv);
    check("done load no pulse", 32'(nv), 32'd0);

    // Reset in mid-conversion, coincident with a load.
    bus.bin_score = 16'd58;
    bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.load = 1'b1;
    bus.bin_score = 16'd99;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.load = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort bcd", 32'(bus.bcd_score), 32'h0000);
    check("abort overflow", 32'(bus.overflow), 32'd0);
    nv = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.bcd_valid || bus.busy) nv++;
    end
    $display("seq reset: stray activity=%0d bcd=%h", nv, bus.bcd_score);
    check("abort no pulse", 32'(nv), 32'd0);
    check("abort bcd held", 32'(bus.bcd_score), 32'h0000);
    run_conv(16'd7, got, ovf, lat, bcnt);
    $display("seq after reset: bcd=%h lat=%0d", got, lat);
    check("post-reset latency", 32'(lat), 32'd17);
    check("post-reset bcd", 32'(got), 32'h0007);

    for (int i = 0; i < 200; i++) begin
      v = int'($urandom_range(0, 65535));
      run_conv(16'(v), got, ovf, lat, bcnt);
      $display("rand %0d: bin=%0d bcd=%h ovf=%0d", i, v, got, ovf);
      check("rand latency", 32'(lat), 32'd17);
      check("rand bcd", 32'(got), 32'(ref_bcd(v)));
      check("rand overflow", 32'(ovf), 32'(v > SAT));
    end

    // Back-to-back strided sweep; run_conv returns in the first idle cycle.
    v = 0;
    while (v <= SAT) begin
      run_conv(16'(v), got, ovf, lat, bcnt);
      $display("sweep: bin=%0d bcd=%h", v, got);
      check("sweep latency", 32'(lat), 32'd17);
      check("sweep bcd", 32'(got), 32'(ref_bcd(v)));
      if (v == SAT) v = SAT + 1;
      else if (v + 13 > SAT) v = SAT;
      else v = v + 13;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
